// File: rtl/ssem_sequencer_if.sv
// Request, memory handshake and datapath control bundle between the SSEM
// sequencer (master) and its requester / memory / datapath environment (slave).
interface ssem_sequencer_if #(
  parameter int COUNT_W = 8
);
  logic               start;
  logic [1:0]         op;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;
  logic [1:0]         mem_sel;
  logic               load_A;
  logic               load_B;
  logic               a_to_bus;
  logic               b_to_bus;
  logic               alu_to_bus;
  logic               alu_sub;
  logic               alu_latch;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] op_count;

  modport master (
    input  start, op, mem_ready,
    output mem_read, mem_write, mem_sel, load_A, load_B,
           a_to_bus, b_to_bus, alu_to_bus, alu_sub, alu_latch,
           busy, done, error, op_count
  );

  modport slave (
    output start, op, mem_ready,
    input  mem_read, mem_write, mem_sel, load_A, load_B,
           a_to_bus, b_to_bus, alu_to_bus, alu_sub, alu_latch,
           busy, done, error, op_count
  );
endinterface

// File: rtl/ssem_sequencer.sv
// Control sequencer for the SSEM datapath: runs the memory handshake and
// steps register loads, bus drives and the ALU for one operation at a time.
module ssem_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  ssem_sequencer_if.master sq
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_EXEC, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] OP_MOVA = 2'b10;
  localparam logic [1:0] OP_MOVB = 2'b11;

  localparam int              WCNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WCNT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;

  logic in_wait;
  logic timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      wait_q     <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_q     <= wait_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_wait = (state_q == S_FETCH_A) || (state_q == S_FETCH_B) || (state_q == S_WRITE);
  // The last permitted wait cycle without an ack aborts instead of loading or writing.
  assign timeout = (wait_q == WAIT_LAST) && !sq.mem_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (sq.start) begin
          op_d    = sq.op;
          state_d = (sq.op == OP_MOVB) ? S_FETCH_B : S_FETCH_A;
        end
      end
      S_FETCH_A: begin
        if (sq.mem_ready)  state_d = (op_q == OP_MOVA) ? S_WRITE : S_FETCH_B;
        else if (timeout)  state_d = S_ERROR;
      end
      S_FETCH_B: begin
        if (sq.mem_ready)  state_d = (op_q == OP_MOVB) ? S_WRITE : S_EXEC;
        else if (timeout)  state_d = S_ERROR;
      end
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: begin
        if (sq.mem_ready)  state_d = S_DONE;
        else if (timeout)  state_d = S_ERROR;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (op_count_q != {COUNT_W{1'b1}}) op_count_d = op_count_q + 1'b1;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Staying in a wait state implies no ack this cycle; any state change restarts the count.
    if (!in_wait || (state_d != state_q)) wait_d = '0;
    else                                   wait_d = wait_q + 1'b1;
  end

  always_comb begin
    sq.mem_read   = 1'b0;
    sq.mem_write  = 1'b0;
    sq.mem_sel    = 2'd3;
    sq.load_A     = 1'b0;
    sq.load_B     = 1'b0;
    sq.a_to_bus   = 1'b0;
    sq.b_to_bus   = 1'b0;
    sq.alu_to_bus = 1'b0;
    sq.alu_sub    = 1'b0;
    sq.alu_latch  = 1'b0;
    sq.done       = 1'b0;
    sq.error      = 1'b0;
    sq.busy       = (state_q != S_IDLE);
    case (state_q)
      S_FETCH_A: begin
        sq.mem_read = 1'b1;
        sq.mem_sel  = 2'd0;
        sq.load_A   = sq.mem_ready;
      end
      S_FETCH_B: begin
        sq.mem_read = 1'b1;
        sq.mem_sel  = 2'd1;
        sq.load_B   = sq.mem_ready;
      end
      S_EXEC: begin
        sq.alu_latch = 1'b1;
        sq.alu_sub   = op_q[0];
      end
      S_WRITE: begin
        sq.mem_write = 1'b1;
        sq.mem_sel   = 2'd2;
        case (op_q)
          OP_MOVA: sq.a_to_bus   = 1'b1;
          OP_MOVB: sq.b_to_bus   = 1'b1;
          default: sq.alu_to_bus = 1'b1;
        endcase
      end
      S_DONE:  sq.done  = 1'b1;
      S_ERROR: sq.error = 1'b1;
      default: ;
    endcase
  end

  assign sq.op_count = op_count_q;

endmodule

// File: tb/tb_ssem_sequencer.sv
// Directed and randomized bench for ssem_sequencer: a memory responder with
// per-address ack delays, a completion scoreboard and per-cycle output checks.
module tb_ssem_sequencer;
  localparam int WL = 15;
  localparam int CW = 8;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MOVA = 2'b10, MOVB = 2'b11;

  logic clk = 1'b0;
  logic reset;

  ssem_sequencer_if #(.COUNT_W(CW)) sif ();
  ssem_sequencer #(.WAIT_LIMIT(WL), .COUNT_W(CW)) dut (.clk(clk), .reset(reset), .sq(sif));

  always #5 clk = ~clk;

  typedef struct {
    bit       err;
    int       lat;
    int       cnt;
    bit [2:0] bus;
    int       n_a;
    int       n_b;
    int       n_l;
    bit       sub;
  } exp_t;

  exp_t sb[$];
  int   rises[$];
  int   checks = 0;
  int   errors = 0;
  int   negcnt = 0;
  int   exp_cnt = 0;
  int   dly[3];
  bit   stress = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference timing: each wait state lasts delay+1 cycles, or WL cycles then ERROR.
  function automatic exp_t model(input logic [1:0] o, input int da, input int db, input int dw);
    exp_t e;
    bit   alive;
    e.err = 0; e.lat = 0; e.cnt = 0; e.bus = 3'b000;
    e.n_a = 0; e.n_b = 0; e.n_l = 0; e.sub = 0;
    alive = 1;
    if (o != MOVB) begin
      if (da >= WL) begin e.lat += WL; alive = 0; end
      else begin e.lat += da + 1; e.n_a = 1; end
    end
    if (alive && o != MOVA) begin
      if (db >= WL) begin e.lat += WL; alive = 0; end
      else begin e.lat += db + 1; e.n_b = 1; end
    end
    if (alive && !o[1]) begin
      e.lat += 1; e.n_l = 1; e.sub = o[0];
    end
    if (alive) begin
      e.bus = (o == MOVA) ? 3'b001 : (o == MOVB) ? 3'b010 : 3'b100;
      if (dw >= WL) begin e.lat += WL; alive = 0; end
      else e.lat += dw + 1;
    end
    e.lat += 1;
    e.err = !alive;
    return e;
  endfunction

  task automatic push_exp(input logic [1:0] o, input int da, input int db, input int dw);
    exp_t e;
    e = model(o, da, db, dw);
    if (!e.err && exp_cnt < 255) exp_cnt++;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Memory responder and monitor
  logic [3:0] prev_key = 4'h0;
  int         rcnt = 0;
  bit         prev_busy = 1'b0;
  int         rise_at = 0;
  int         n_a = 0, n_b = 0, n_l = 0;
  bit [2:0]   bus_seen = 3'b000;
  bit         sub_seen = 1'b0;
  bit         cnt_pend = 1'b0;
  int         cnt_exp_v = 0;

  always begin
    logic [3:0] key;
    logic       active;
    exp_t       e;
    @(negedge clk);
    negcnt++;
    key    = {sif.mem_read, sif.mem_write, sif.mem_sel};
    active = sif.mem_read | sif.mem_write;
    if (active && key == prev_key) rcnt++;
    else rcnt = 0;
    prev_key = key;
    if (active) sif.mem_ready = (rcnt == ((sif.mem_sel < 2'd3) ? dly[sif.mem_sel] : 0));
    else        sif.mem_ready = stress ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("bus_exclusive", 32'($countones({sif.a_to_bus, sif.b_to_bus, sif.alu_to_bus}) <= 1), 1);
    chk("load_A", 32'(sif.load_A), 32'(sif.mem_read && sif.mem_sel == 2'd0 && sif.mem_ready));
    chk("load_B", 32'(sif.load_B), 32'(sif.mem_read && sif.mem_sel == 2'd1 && sif.mem_ready));
    chk("alu_sub_outside_exec", 32'(sif.alu_sub & ~sif.alu_latch), 0);
    if (!sif.busy)
      chk("idle_outputs", 32'({sif.mem_read, sif.mem_write, sif.load_A, sif.load_B, sif.a_to_bus,
                               sif.b_to_bus, sif.alu_to_bus, sif.alu_sub, sif.alu_latch, sif.done,
                               sif.error, sif.mem_sel}), 32'h3);
    if (cnt_pend) begin
      chk("op_count", 32'(sif.op_count), 32'(cnt_exp_v));
      cnt_pend = 1'b0;
    end
    if (sif.busy && !prev_busy) begin
      rises.push_back(negcnt);
      rise_at  = negcnt;
      n_a = 0; n_b = 0; n_l = 0;
      bus_seen = 3'b000;
      sub_seen = 1'b0;
    end
    n_a += int'(sif.load_A);
    n_b += int'(sif.load_B);
    n_l += int'(sif.alu_latch);
    bus_seen |= {sif.alu_to_bus, sif.b_to_bus, sif.a_to_bus};
    sub_seen |= sif.alu_sub;
    if (sif.done || sif.error) begin
      if (sb.size() == 0) chk("unexpected_completion", 1, 0);
      else begin
        e = sb.pop_front();
        chk("error_vs_done", 32'(sif.error), 32'(e.err));
        chk("latency", 32'(negcnt - rise_at + 1), 32'(e.lat));
        chk("load_A_count", 32'(n_a), 32'(e.n_a));
        chk("load_B_count", 32'(n_b), 32'(e.n_b));
        chk("alu_latch_count", 32'(n_l), 32'(e.n_l));
        chk("write_bus_source", 32'(bus_seen), 32'(e.bus));
        chk("alu_sub", 32'(sub_seen), 32'(e.sub));
        cnt_pend  = 1'b1;
        cnt_exp_v = e.cnt;
      end
    end
    prev_busy = sif.busy;
  end

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      sif.start = stress ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stress) sif.op = 2'($urandom_range(0, 3));
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
    sif.start = 1'b0;
    #2;
  endtask

  task automatic run_op(input logic [1:0] o, input int da, input int db, input int dw);
    @(negedge clk);
    dly[0] = da; dly[1] = db; dly[2] = dw;
    sif.op    = o;
    sif.start = 1'b1;
    push_exp(o, da, db, dw);
    drain(200);
  endtask

  function automatic int rand_dly();
    int r;
    r = int'($urandom_range(0, 63));
    if (r == 0) return WL;
    if (r == 1) return WL - 1;
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    int n;
    reset     = 1'b1;
    sif.start = 1'b0;
    sif.op    = 2'b00;
    dly[0] = 0; dly[1] = 0; dly[2] = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", 32'(sif.busy), 0);
    chk("reset_mem_sel", 32'(sif.mem_sel), 3);
    chk("reset_op_count", 32'(sif.op_count), 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(ADD, 0, 0, 0);
    run_op(SUB, 3, 3, 3);
    run_op(MOVA, 0, 2, 1);
    run_op(MOVB, 5, 0, 2);
    run_op(ADD, 0, 99, 0);
    run_op(ADD, 0, WL - 1, 0);
    run_op(SUB, 99, 0, 0);
    run_op(MOVA, 0, 0, 99);
    run_op(MOVB, 0, WL - 1, WL - 1);

    // Back-to-back ADDs with start held high
    @(negedge clk);
    dly[0] = 0; dly[1] = 0; dly[2] = 0;
    sif.op    = ADD;
    sif.start = 1'b1;
    rises.delete();
    push_exp(ADD, 0, 0, 0);
    push_exp(ADD, 0, 0, 0);
    n = 0;
    while (rises.size() < 2 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    sif.start = 1'b0;
    chk("b2b_second_accept", 32'(rises.size() >= 2), 1);
    if (rises.size() >= 2) chk("b2b_period", 32'(rises[1] - rises[0]), 6);
    drain(60);

    // Reset asserted in the middle of WRITE
    @(negedge clk);
    dly[0] = 0; dly[1] = 0; dly[2] = 99;
    sif.op    = ADD;
    sif.start = 1'b1;
    push_exp(ADD, 0, 0, 99);
    @(negedge clk);
    sif.start = 1'b0;
    #2;
    n = 0;
    while (!sif.mem_write && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("reached_write", 32'(sif.mem_write), 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", 32'({sif.mem_write, sif.alu_to_bus, sif.busy, sif.done, sif.error}), 0);
    chk("midreset_mem_sel", 32'(sif.mem_sel), 3);
    chk("midreset_op_count", 32'(sif.op_count), 0);
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    stress = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] o;
      int da, db, dw;
      o  = 2'($urandom_range(0, 3));
      da = rand_dly();
      db = rand_dly();
      dw = rand_dly();
      run_op(o, da, db, dw);
    end
    stress = 1'b0;

    @(negedge clk);
    #2;
    chk("op_count_saturated", 32'(sif.op_count), 255);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
